frame_buffer_pingpong: RTL

Double-buffered pixel store between the accelerator's pixel compute engine and the display scan-out. The writer fills a back bank while the reader scans the front bank; banks swap only when the writer has finished a frame and the reader reaches a frame boundary, so scan-out never shows a partially computed frame. It is a parametrised successor to the single-bank pixel RAM, adding banking, a swap handshake, write back-pressure, read-valid tracking and an optional bank-clear engine.

---
 rtl/frame_buffer_pingpong.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/frame_buffer_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_pingpong
// Brief    : Two-bank pixel store; writer fills the back bank while the reader
//            scans the front bank, swapping only at a reader frame boundary.
//            Define FB_CLEAR_EN to clear each new back bank after a swap.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_pingpong #(
    parameter int                    ADDRESS_WIDTH = 20,
    parameter int                    DATA_WIDTH    = 15,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic                     wr_ready,
    input  logic                     wr_frame_done,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic                     rd_frame_done,
    output logic [DATA_WIDTH-1:0]    RGB,
    output logic                     rd_valid,
    output logic                     front_sel,
    output logic                     swap_pending,
    output logic [15:0]              frame_count
);

    localparam int c_WORDS = 2 * (2 ** ADDRESS_WIDTH);

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_WAIT_SWAP = 2'd1,
        ST_CLEAR     = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_WAIT_SWAP = 2'd1
    } state_t;
`endif

    state_t                  r_state;
    logic                    r_front_sel;
    logic [15:0]             r_frame_count;
    logic [DATA_WIDTH-1:0]   r_rgb;
    logic                    r_rd_valid;
    logic [DATA_WIDTH-1:0]   r_mem [0:c_WORDS-1];

    logic                    w_wr_ready;
    logic                    w_wr_fire;
    logic                    w_swap;

`ifdef FB_CLEAR_EN
    logic [ADDRESS_WIDTH-1:0] r_clr_addr;
`else
    logic [DATA_WIDTH-1:0]    w_unused_clear_value;
    assign w_unused_clear_value = CLEAR_VALUE;
`endif

    assign w_wr_ready = (r_state == ST_FILL);
    assign w_wr_fire  = wr_en && w_wr_ready;
    // Simultaneous done pulses in FILL swap directly without visiting WAIT_SWAP.
    assign w_swap     = rd_frame_done &&
                        ((r_state == ST_WAIT_SWAP) || ((r_state == ST_FILL) && wr_frame_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FILL;
            r_front_sel   <= 1'b0;
            r_frame_count <= 16'd0;
`ifdef FB_CLEAR_EN
            r_clr_addr    <= '0;
`endif
        end else if (w_swap) begin
            r_front_sel   <= ~r_front_sel;
            r_frame_count <= r_frame_count + 16'd1;
`ifdef FB_CLEAR_EN
            r_state       <= ST_CLEAR;
            r_clr_addr    <= '0;
`else
            r_state       <= ST_FILL;
`endif
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (wr_frame_done) begin
                        r_state <= ST_WAIT_SWAP;
                    end
                end
                ST_WAIT_SWAP: begin
                    r_state <= ST_WAIT_SWAP;
                end
`ifdef FB_CLEAR_EN
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (&r_clr_addr) begin
                        r_state <= ST_FILL;
                    end
                end
`endif
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    // Writes and clear always target the back bank; they are mutually exclusive.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[{~r_front_sel, wr_addr}] <= din;
        end
`ifdef FB_CLEAR_EN
        else if (r_state == ST_CLEAR) begin
            r_mem[{~r_front_sel, r_clr_addr}] <= CLEAR_VALUE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rgb <= r_mem[{r_front_sel, rd_addr}];
            end
        end
    end

    assign wr_ready     = w_wr_ready;
    assign swap_pending = (r_state == ST_WAIT_SWAP);
    assign front_sel    = r_front_sel;
    assign frame_count  = r_frame_count;
    assign RGB          = r_rgb;
    assign rd_valid     = r_rd_valid;

endmodule
`default_nettype wire
